// File: rtl/seq_sub_pkg.sv
// Shared types and elaboration helpers for the sequential borrow-select subtractor.
package seq_sub_pkg;

    // Controller states: waiting for operands, walking slices, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-bit slices needed to cover WIDTH bits.
    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // True when the slice width evenly tiles the operand width.
    function automatic bit chunk_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/borrow_select_slice.sv
// One CHUNK-bit subtract slice: both borrow-in outcomes are formed up front and
// the incoming borrow only has to steer a 2:1 mux.
module borrow_select_slice
    import seq_sub_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             sel_borrow,
    output logic [CHUNK-1:0] d,
    output logic             borrow_out
);

    logic [CHUNK:0] d0_ext;
    logic [CHUNK:0] d1_ext;

    // Precompute the no-borrow and borrow variants, then pick one with the borrow.
    always_comb begin
        d0_ext = {1'b0, a_i} - {1'b0, b_i};
        d1_ext = {1'b0, a_i} - {1'b0, b_i} - {{CHUNK{1'b0}}, 1'b1};
        if (sel_borrow) begin
            d          = d1_ext[CHUNK-1:0];
            borrow_out = d1_ext[CHUNK];
        end else begin
            d          = d0_ext[CHUNK-1:0];
            borrow_out = d0_ext[CHUNK];
        end
    end

endmodule

// File: rtl/seq_borrow_select_subtractor.sv
// Multi-cycle a - b - bin: one slice per cycle, LSB slice first, with a
// valid/ready handshake on each side so it can sit between pipeline registers.
module seq_borrow_select_subtractor
    import seq_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    // Refuse to elaborate a slice width that does not tile the operand.
    if (!chunk_ok(WIDTH, CHUNK)) begin : g_param_check
        $error("seq_borrow_select_subtractor: WIDTH must be a positive multiple of CHUNK");
    end

    state_t            state;
    state_t            state_next;
    logic [IDXW-1:0]   idx;
    logic              borrow_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  diff_q;
    logic [WIDTH-1:0]  diff_next;
    logic              bout_q;
    logic              zero_q;
    logic              ovf_q;
    logic [CHUNK-1:0]  slice_a;
    logic [CHUNK-1:0]  slice_b;
    logic [CHUNK-1:0]  slice_d;
    logic              slice_bout;
    logic              accept;
    logic              last_slice;

    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
    assign ovf  = ovf_q;

    assign accept     = in_valid && in_ready;
    assign last_slice = (idx == LAST_IDX);

    // Pick the operand slice addressed by the running index.
    always_comb begin
        slice_a = a_q[idx*CHUNK +: CHUNK];
        slice_b = b_q[idx*CHUNK +: CHUNK];
    end

    borrow_select_slice #(
        .CHUNK(CHUNK)
    ) u_slice (
        .a_i        (slice_a),
        .b_i        (slice_b),
        .sel_borrow (borrow_q),
        .d          (slice_d),
        .borrow_out (slice_bout)
    );

    // The full difference as it will look once this cycle's slice is stored;
    // the exit flags are taken from it so they see the final slice too.
    always_comb begin
        diff_next = diff_q;
        diff_next[idx*CHUNK +: CHUNK] = slice_d;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; in_ready depends only on state and reset.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, slice walk, borrow chain and result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        idx      <= '0;
                    end
                end
                RUN: begin
                    diff_q   <= diff_next;
                    borrow_q <= slice_bout;
                    if (last_slice) begin
                        idx    <= '0;
                        bout_q <= slice_bout;
                        zero_q <= (diff_next == '0);
                        ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                  (diff_next[WIDTH-1] != a_q[WIDTH-1]);
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_borrow_select_subtractor.sv
// Self-checking bench for seq_borrow_select_subtractor: directed cases plus
// random operations checked against an arithmetic reference.
module tb_seq_borrow_select_subtractor;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             ovf;

    int total = 0;
    int bad   = 0;

    seq_borrow_select_subtractor #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero),
        .ovf       (ovf)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so a stuck design still ends the run.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, wanted finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic mbin,
                         output logic [WIDTH-1:0] ed, output logic eb, output logic ez, output logic eo);
        int ua, ub, sa, sb, sres;
        ua   = int'(ma);
        ub   = int'(mb);
        ed   = WIDTH'(ua - ub - int'(mbin));
        eb   = (ua < ub + int'(mbin));
        ez   = (ed == 0);
        sa   = (ua >= (1 << (WIDTH-1))) ? ua - (1 << WIDTH) : ua;
        sb   = (ub >= (1 << (WIDTH-1))) ? ub - (1 << WIDTH) : ub;
        sres = sa - sb - int'(mbin);
        eo   = (sres > (1 << (WIDTH-1)) - 1) || (sres < -(1 << (WIDTH-1)));
    endtask

    // Wait for in_ready, present one operand set for a single handshake, then scramble inputs.
    task automatic applyStimulus(input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sb, input logic sbin);
        int w = 0;
        while (!in_ready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("[TB] FAIL accept_wait: in_ready got %0b, wanted 1 within 40 cycles", in_ready);
        end
        a = sa; b = sb; bin = sbin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a   = WIDTH'($urandom);
        b   = WIDTH'($urandom);
        bin = 1'($urandom);
    endtask

    // Called just after the accepting edge: check latency and results, then pop the result.
    task automatic finish_op(input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb_in, input logic ebin,
                             input string name);
        logic [WIDTH-1:0] ed;
        logic eb, ez, eo;
        int cyc = 0;
        model(ea, eb_in, ebin, ed, eb, ez, eo);
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (cyc !== NCHUNK) begin
            bad++;
            $display("[TB] FAIL %s latency: got %0d cycles, wanted %0d", name, cyc, NCHUNK);
        end
        total++;
        if (diff !== ed) begin
            bad++;
            $display("[TB] FAIL %s diff: got %h, wanted %h (a=%h b=%h bin=%0b)", name, diff, ed, ea, eb_in, ebin);
        end
        total++;
        if (bout !== eb) begin
            bad++;
            $display("[TB] FAIL %s bout: got %0b, wanted %0b", name, bout, eb);
        end
        total++;
        if (zero !== ez) begin
            bad++;
            $display("[TB] FAIL %s zero: got %0b, wanted %0b", name, zero, ez);
        end
        total++;
        if (ovf !== eo) begin
            bad++;
            $display("[TB] FAIL %s ovf: got %0b, wanted %0b", name, ovf, eo);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s in_ready_done: got %0b, wanted 0", name, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s pop: got out_valid=%0b in_ready=%0b, wanted 0 and 1", name, out_valid, in_ready);
        end
    endtask

    // Reset held two cycles clears everything; ready appears once reset drops.
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || diff !== '0 || bout !== 1'b0 || zero !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got v=%0b d=%h b=%0b z=%0b o=%0b, wanted all 0",
                     out_valid, diff, bout, zero, ovf);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_in_ready: got %0b, wanted 0 while rst=1", in_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL post_reset: got in_ready=%0b out_valid=%0b, wanted 1 and 0", in_ready, out_valid);
        end
    endtask

    // Directed cases: basic, borrow ripple through slices, overflow and zero.
    task automatic test_directed();
        applyStimulus(16'h1234, 16'h0034, 1'b0);
        finish_op(16'h1234, 16'h0034, 1'b0, "basic");
        applyStimulus(16'h0100, 16'h0001, 1'b0);
        finish_op(16'h0100, 16'h0001, 1'b0, "borrow_chain");
        applyStimulus(16'h0000, 16'h0001, 1'b0);
        finish_op(16'h0000, 16'h0001, 1'b0, "borrow_out");
        applyStimulus(16'h8000, 16'h0001, 1'b0);
        finish_op(16'h8000, 16'h0001, 1'b0, "overflow");
        applyStimulus(16'h0005, 16'h0004, 1'b1);
        finish_op(16'h0005, 16'h0004, 1'b1, "zero_bin");
        applyStimulus(16'h0000, 16'hFFFF, 1'b1);
        finish_op(16'h0000, 16'hFFFF, 1'b1, "max_borrow");
    endtask

    // Random back-to-back operations, some forced to land on a zero difference.
    task automatic test_random();
        logic [WIDTH-1:0] ra, rb;
        logic rbin;
        for (int i = 0; i < 24; i++) begin
            ra   = WIDTH'($urandom);
            rb   = WIDTH'($urandom);
            rbin = 1'($urandom);
            if (i % 6 == 0) begin
                rb = ra - WIDTH'(rbin);
            end
            applyStimulus(ra, rb, rbin);
            finish_op(ra, rb, rbin, "random");
        end
    endtask

    // Result must hold while the consumer stalls; new operands wait until IDLE.
    task automatic test_backpressure();
        logic [WIDTH-1:0] ed;
        logic eb, ez, eo;
        int cyc = 0;
        model(16'hA5A5, 16'h5A5B, 1'b1, ed, eb, ez, eo);
        applyStimulus(16'hA5A5, 16'h5A5B, 1'b1);
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        a = 16'h0F00; b = 16'h0E01; bin = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== ed || bout !== eb || ovf !== eo || zero !== ez) begin
                bad++;
                $display("[TB] FAIL stall_hold: got v=%0b r=%0b d=%h b=%0b o=%0b z=%0b, wanted 1 0 %h %0b %0b %0b",
                         out_valid, in_ready, diff, bout, ovf, zero, ed, eb, eo, ez);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_release: got in_ready=%0b out_valid=%0b, wanted 1 and 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'hFFFF; b = 16'hFFFF;
        finish_op(16'h0F00, 16'h0E01, 1'b0, "after_stall");
    endtask

    // Reset in the second RUN cycle drops the operation; a fresh one then works.
    task automatic test_reset_mid_run();
        applyStimulus(16'h4321, 16'h1234, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || diff !== '0 || bout !== 1'b0 || zero !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrun_reset: got v=%0b d=%h b=%0b z=%0b o=%0b, wanted all 0",
                     out_valid, diff, bout, zero, ovf);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midrun_idle: in_ready got %0b, wanted 1", in_ready);
        end
        for (int k = 0; k < NCHUNK + 2; k++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL midrun_discard: out_valid got %0b, wanted 0", out_valid);
            end
        end
        applyStimulus(16'h7FFF, 16'hFFFF, 1'b0);
        finish_op(16'h7FFF, 16'hFFFF, 1'b0, "after_midrun");
    endtask

    // Test sequence.
    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
